// File: rtl/gcd_controller_if.sv
// gcd_controller_if: host handshake and datapath control/flag bundle for the GCD controller.
interface gcd_controller_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic [WIDTH-1:0] iter_count;
    logic [WIDTH-1:0] dp_A;
    logic [WIDTH-1:0] dp_B;
    logic             dp_sub_A;
    logic             dp_sub_B;
    logic             dp_result;
    logic [WIDTH-1:0] dp_final_value;
    logic             dp_ANEB;
    logic             dp_AGTB;
    modport master (
        output start, a_in, b_in, dp_final_value, dp_ANEB, dp_AGTB,
        input  busy, done, gcd_out, iter_count, dp_A, dp_B, dp_sub_A, dp_sub_B, dp_result
    );
    modport slave (
        input  start, a_in, b_in, dp_final_value, dp_ANEB, dp_AGTB,
        output busy, done, gcd_out, iter_count, dp_A, dp_B, dp_sub_A, dp_sub_B, dp_result
    );
endinterface

// File: rtl/gcd_controller.sv
// gcd_controller: FSM sequencing a subtractive GCD datapath with start/busy/done handshake.
module gcd_controller #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    gcd_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMP, SUBA, SUBB, RESULT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, gcd_q, gcd_d, iter_q, iter_d;
    logic             zero_op, accept;
    logic [WIDTH-1:0] cnt_inc;
    assign zero_op = (bus.a_in == '0) || (bus.b_in == '0);
    assign accept  = (state_q == IDLE) && bus.start;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = !bus.start ? IDLE : zero_op ? DONE : CMP;
            CMP:        state_d = !bus.dp_ANEB ? RESULT : bus.dp_AGTB ? SUBA : SUBB;
            SUBA, SUBB: state_d = CMP;
            RESULT:     state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end
    // Only the smaller operand is ever subtracted from the larger, so no underflow.
    always_comb begin
        a_d    = (accept && !zero_op) ? bus.a_in : (state_q == SUBA) ? a_q - b_q : a_q;
        b_d    = (accept && !zero_op) ? bus.b_in : (state_q == SUBB) ? b_q - a_q : b_q;
        cnt_d  = (accept && !zero_op) ? '0 : (state_q == SUBA || state_q == SUBB) ? cnt_inc : cnt_q;
        gcd_d  = (accept && zero_op) ? (bus.a_in | bus.b_in) : (state_q == RESULT) ? bus.dp_final_value : gcd_q;
        iter_d = (accept && zero_op) ? '0 : (state_q == RESULT) ? cnt_q : iter_q;
    end
    always_comb begin
        bus.busy       = (state_q == CMP) || (state_q == SUBA) || (state_q == SUBB) || (state_q == RESULT);
        bus.done       = state_q == DONE;
        bus.dp_sub_A   = state_q == SUBA;
        bus.dp_sub_B   = state_q == SUBB;
        bus.dp_result  = state_q == RESULT;
        bus.dp_A       = a_q;
        bus.dp_B       = b_q;
        bus.gcd_out    = gcd_q;
        bus.iter_count = iter_q;
    end
endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- FSM controller that sequences the combinational GCD datapath using repeated subtraction.
- Holds both operands in registers and drives them onto the datapath's A/B inputs.
- Steers the datapath from its ANEB/AGTB flags: asserts sub_A/sub_B while subtracting and result when finished.
- Provides the host with a start/busy/done handshake, a registered GCD result and a subtraction-step count.

Parameters:
- WIDTH, 8, operand/result width; also the width of the step counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  operand A, captured when start is accepted.
- b_in  in  WIDTH  operand B, captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the cycle before done.
- done  out  1  one-cycle pulse; gcd_out and iter_count are valid from this cycle onward.
- gcd_out  out  WIDTH  registered result; holds until the next completion.
- iter_count  out  WIDTH  subtraction steps used by the last operation; saturates at all-ones.
- dp_A  out  WIDTH  operand register a_q to the datapath.
- dp_B  out  WIDTH  operand register b_q to the datapath.
- dp_sub_A  out  1  datapath sub_A control.
- dp_sub_B  out  1  datapath sub_B control.
- dp_result  out  1  datapath result control.
- dp_final_value  in  WIDTH  datapath output.
- dp_ANEB  in  1  datapath A != B flag.
- dp_AGTB  in  1  datapath A > B flag.

Behaviour:
- Reset values: state=IDLE; a_q, b_q, gcd_out, iter_count = 0; busy, done, dp_sub_A, dp_sub_B, dp_result = 0. Reset has priority over all other events.
- Control outputs are Moore decodes of state: dp_sub_A=1 only in SUBA, dp_sub_B=1 only in SUBB, dp_result=1 only in RESULT.
- busy=1 in CMP, SUBA, SUBB and RESULT.
- done is a registered pulse, high only in DONE.
- IDLE:
  - start=1 with both operands nonzero: a_q<=a_in, b_q<=b_in, clear the step counter, go to CMP.
  - start=1 with a_in==0 or b_in==0: gcd_out<=a_in|b_in (gcd(0,0)=0), iter_count<=0, go to DONE.
- CMP: uses the datapath flags.
  - ANEB & AGTB -> SUBA.
  - ANEB & !AGTB -> SUBB.
  - !ANEB -> RESULT.
- SUBA: a_q<=a_q-b_q, step counter +1 (saturating), go to CMP.
- SUBB: b_q<=b_q-a_q, step counter +1 (saturating), go to CMP.
- RESULT: gcd_out<=dp_final_value, iter_count<=step counter, go to DONE.
- DONE: done=1 for one cycle, go to IDLE. start is not sampled in DONE.
- Latency: start accepted at edge t gives done high in cycle t+3+2N, where N is the number of subtractions. The zero-operand path gives done in cycle t+1.
- Subtraction is WIDTH-bit unsigned. No underflow is possible, because the controller only subtracts the smaller operand from the larger.
- start while busy or in DONE is ignored; the in-flight operation is unaffected.
- a_in/b_in changes after acceptance have no effect.
- rst mid-operation aborts the operation: return to IDLE, all registers cleared, no done pulse.
- Back-to-back: start asserted in the cycle after done is accepted normally.

Test Plan:
- Reset, then start with a_in=12, b_in=8 -> one SUBA then one SUBB; done at t+7; gcd_out=4, iter_count=2; busy low after done.
- a_in=9, b_in=9 -> no dp_sub_A/dp_sub_B pulses; dp_result high one cycle; done at t+3; gcd_out=9, iter_count=0.
- a_in=255, b_in=1 (WIDTH=8) -> 254 SUBA steps; done at t+511; gcd_out=1, iter_count=254.
- a_in=0, b_in=7 -> done at t+1, gcd_out=7, iter_count=0. Then a_in=0, b_in=0 -> gcd_out=0.
- start a_in=12, b_in=8 then start pulsed with a_in=5, b_in=3 while busy -> ignored; result 4. Next start with 21/14 in the cycle after done -> gcd_out=7, iter_count=2.
- Assert rst for 1 cycle during a 255/1 run -> busy=0, done never pulses, gcd_out=0, iter_count=0, state IDLE. A new start with 6/4 -> gcd_out=2.
